uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Sequencing controller for the UART receive path. It oversamples the serial line, detects and qualifies the start bit, and takes three mid-bit samples per bit to form a majority vote. It drives the receive shift register's clear, bit-value and bit-index inputs, and flags frame completion and errors to the host logic. It sits between the pad-side `rx` line and the 8-bit receive shift register.

## Interface
- `OSR`, 16: oversampling ratio, meaning `i_tick` pulses per bit period; legal values are even, 8..64.
- `CNT_W`, 6: width of the tick counter; must satisfy 2^CNT_W ≥ OSR.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low; clock clk.
- `i_tick`  in  1  one-clk enable pulse at OSR × baud rate.
- `i_rx`  in  1  asynchronous serial input; idle level is 1.
- `o_shift_rst`  out  1  one-cycle clear pulse to the shift register.
- `o_catch_bit`  out  1  majority-voted bit value.
- `o_catch_bit_cnt`  out  4  target bit index, 0..7; parked at 4'd8, which is a no-op write.
- `o_rx_done`  out  1  one-cycle pulse: a frame was received with a valid stop bit.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `o_parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration).
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- `i_rx` passes through a 2-flop synchronizer. The name `rx_s` below refers to the synchronized value.
- The tick counter `tc` counts 0..OSR-1 and advances only on `i_tick`.
  - Sample points are `tc` = OSR/2-1, OSR/2 and OSR/2+1.
  - The majority result is 1 when two or more of the three samples are 1.
  - The vote is computed on the tick at the third sample point.
- States:
  - **IDLE:** on a tick with `rx_s`=0, enter START with `tc`=0.
  - **START:** at the third sample, if the vote is 1 (false start), go to IDLE. If the vote is 0, pulse `o_shift_rst` that cycle. At `tc`=OSR-1, go to DATA with bit index k=0.
  - **DATA:** at each third sample:
    - register `o_catch_bit`=vote and `o_catch_bit_cnt`=k in the same cycle;
    - hold both until the next vote;
    - at `tc`=OSR-1, k increments;
    - after k=7 completes, go to STOP (or PARITY when configured).
    - Bits arrive LSB first.
  - **STOP:** at the third sample, act on the vote, then go to IDLE immediately (half-bit early, which allows resynchronization on back-to-back frames):
    - vote 1: pulse `o_rx_done`.
    - vote 0: pulse `o_frame_err` and do not pulse `o_rx_done`.
- `o_catch_bit_cnt` returns to 8 on leaving DATA. It reads 8 in IDLE, START and STOP.
- In IDLE, `rx_s`=0 without `i_tick` does not start a frame.
- A `rx_s` change between ticks is not sampled.

## Timing
- Reset values:
  - state IDLE, `tc`=0;
  - `o_catch_bit`=0, `o_catch_bit_cnt`=8;
  - all pulses 0, `o_busy`=0.
- All outputs are registered.
- Pulses last exactly one clk.
- Input latency is 2 clk (synchronizer).
- The shift register captures bit k on the clk after the vote. Its 8-bit data is therefore stable at least one bit period before `o_rx_done`.
- Frame length from the start tick to `o_rx_done` is 9·OSR + OSR/2+1 ticks. With parity it is 10·OSR + OSR/2+1 ticks.
- Asserting `rst_n` mid-frame returns the block to IDLE and the reset values at once. No pulse is emitted.
- `i_tick` held high continuously is legal: the block counts one tick per clk.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - a PARITY state sits between DATA and STOP and lasts one bit period;
  - its vote is compared with even parity (the XOR of the 8 voted data bits, tracked internally);
  - on a mismatch, `o_parity_err` pulses alongside the STOP-phase `o_rx_done`/`o_frame_err`;
  - `o_catch_bit_cnt` stays 8 during PARITY.
- **Undefined:** there is no PARITY state, and `o_parity_err` is tied to 0.

## Test plan
- **Nominal frame:** OSR=16, frame 0xA5 (start, 10100101 sent LSB first, stop). Require:
  - one `o_shift_rst` pulse;
  - a `o_catch_bit_cnt` sequence of 0..7;
  - one `o_rx_done` pulse;
  - shift register = 8'hA5;
  - `o_frame_err`=0.
- **False start:** `i_rx` low for 4 ticks, then high. Require a return to IDLE with no `o_shift_rst` and no `o_rx_done`, and `o_busy` high for ≤ OSR/2+2 ticks.
- **Glitch rejection:** frame 0x3C with a single-tick inverted glitch at `tc`=OSR/2 of bit 2 and of bit 5. Require shift register = 8'h3C.
- **Framing error:** frame 0xFF with the stop bit held 0. Require one `o_frame_err` pulse and no `o_rx_done`. Then restore the line and send 0x12: require `o_rx_done` with data 8'h12.
- **Back-to-back and reset:** send 0x55 and 0xAA with no idle gap; require two `o_rx_done` pulses with the correct data. Then assert `rst_n` during bit 4 of a third frame; require `o_busy`=0, `o_catch_bit_cnt`=8, and no `o_rx_done` pulse.
- **With `UART_RX_PARITY_EN`:**
  - 0x07 with parity bit 1: require `o_rx_done`, and `o_parity_err`=0.
  - 0x07 with parity bit 0: require `o_rx_done` and `o_parity_err` in the same cycle.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-path sequencer for a UART. Oversamples the serial line,
// qualifies the start bit with a 3-sample majority vote, and steers the 8-bit
// receive shift register through clear / bit-value / bit-index outputs.
// Optional parity phase: define UART_RX_PARITY_EN to insert a PARITY state
// (even parity) between the data bits and the stop bit.
module uart_rx_ctrl #(
  parameter int OSR   = 16,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_rx,
  output logic       o_shift_rst,
  output logic       o_catch_bit,
  output logic [3:0] o_catch_bit_cnt,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  // Tick-counter landmarks within one bit period.
  localparam logic [CNT_W-1:0] TC_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TC_SMP0 = CNT_W'(OSR / 2 - 1);
  localparam logic [CNT_W-1:0] TC_SMP1 = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0] TC_SMP2 = CNT_W'(OSR / 2 + 1);
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Majority of three samples: 1 when at least two inputs are 1.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic             rx_meta_q;
  logic             rx_sync_q;
  state_e           state_q;
  logic [CNT_W-1:0] tc_q;
  logic [1:0]       smp_q;
  logic [2:0]       bit_idx_q;
  logic             shift_rst_q;
  logic             catch_bit_q;
  logic [3:0]       catch_cnt_q;
  logic             rx_done_q;
  logic             frame_err_q;
  logic             busy_q;
  logic             vote_s;
`ifdef UART_RX_PARITY_EN
  logic             par_acc_q;
  logic             par_err_pend_q;
  logic             parity_err_q;
`endif

  // The vote is only meaningful on the tick at the third sample point.
  assign vote_s = maj3(smp_q[0], smp_q[1], rx_sync_q);

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame sequencer: tick counter, sampling, state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tc_q        <= TC_ZERO;
      smp_q       <= 2'b11;
      bit_idx_q   <= 3'd0;
      shift_rst_q <= 1'b0;
      catch_bit_q <= 1'b0;
      catch_cnt_q <= 4'd8;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_q      <= 1'b0;
      par_err_pend_q <= 1'b0;
      parity_err_q   <= 1'b0;
`endif
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      shift_rst_q <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (i_tick) begin
        tc_q <= (tc_q == TC_LAST) ? TC_ZERO : tc_q + TC_ONE;
        if (tc_q == TC_SMP0) smp_q[0] <= rx_sync_q;
        if (tc_q == TC_SMP1) smp_q[1] <= rx_sync_q;
        case (state_q)
          IDLE: begin
            // The detecting tick is tc=0 of the start bit, so the next
            // tick is processed as tc=1 and mid-bit lands on tc=OSR/2.
            if (!rx_sync_q) begin
              state_q <= START;
              busy_q  <= 1'b1;
              tc_q    <= TC_ONE;
            end else begin
              tc_q <= TC_ZERO;
            end
          end
          START: begin
            if (tc_q == TC_SMP2) begin
              if (vote_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                tc_q    <= TC_ZERO;
              end else begin
                shift_rst_q <= 1'b1;
              end
            end else if (tc_q == TC_LAST) begin
              state_q   <= DATA;
              bit_idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
              par_acc_q <= 1'b0;
`endif
            end
          end
          DATA: begin
            if (tc_q == TC_SMP2) begin
              catch_bit_q <= vote_s;
              catch_cnt_q <= {1'b0, bit_idx_q};
`ifdef UART_RX_PARITY_EN
              par_acc_q   <= par_acc_q ^ vote_s;
`endif
            end else if (tc_q == TC_LAST) begin
              if (bit_idx_q == 3'd7) begin
                catch_cnt_q <= 4'd8;
`ifdef UART_RX_PARITY_EN
                state_q     <= PARITY;
`else
                state_q     <= STOP;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            // Even parity: received bit must equal XOR of the data bits.
            if (tc_q == TC_SMP2) begin
              par_err_pend_q <= vote_s ^ par_acc_q;
            end else if (tc_q == TC_LAST) begin
              state_q <= STOP;
            end
          end
`endif
          STOP: begin
            // Leave half a bit early so a back-to-back start edge is caught.
            if (tc_q == TC_SMP2) begin
              rx_done_q   <= vote_s;
              frame_err_q <= ~vote_s;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_err_pend_q;
`endif
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tc_q    <= TC_ZERO;
            end
          end
          default: begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tc_q        <= TC_ZERO;
            catch_cnt_q <= 4'd8;
          end
        endcase
      end
    end
  end

  assign o_shift_rst     = shift_rst_q;
  assign o_catch_bit     = catch_bit_q;
  assign o_catch_bit_cnt = catch_cnt_q;
  assign o_rx_done       = rx_done_q;
  assign o_frame_err     = frame_err_q;
  assign o_busy          = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err    = parity_err_q;
`else
  assign o_parity_err    = 1'b0;
`endif

endmodule
